// File: rtl/conv_seq_if.sv
// Handshake and operand bundle between the conv engine and its operand/result buffers.
// The producer side (operand buffers plus result consumer) uses master; the engine uses slave.
interface conv_seq_if #(
  parameter int DW   = 8,
  parameter int IN_H = 4,
  parameter int IN_W = 4,
  parameter int K    = 3,
  parameter int OUTW = 8
);
  localparam int OH  = IN_H - K + 1;
  localparam int OWD = IN_W - K + 1;
  localparam int RW  = (OH  > 1) ? $clog2(OH)  : 1;
  localparam int CW  = (OWD > 1) ? $clog2(OWD) : 1;

  logic                     start;
  logic                     flip;
  logic [IN_H*IN_W*DW-1:0]  img_flat;
  logic [K*K*DW-1:0]        ker_flat;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUTW-1:0]          out_data;
  logic [RW-1:0]            out_row;
  logic [CW-1:0]            out_col;
  logic                     done;

  modport master (
    output start, flip, img_flat, ker_flat, out_ready,
    input  busy, out_valid, out_data, out_row, out_col, done
  );

  modport slave (
    input  start, flip, img_flat, ker_flat, out_ready,
    output busy, out_valid, out_data, out_row, out_col, done
  );
endinterface

// File: rtl/conv_seq_engine.sv
// Single-MAC 2-D convolution engine: one product per cycle, stride 1, no padding,
// results streamed out row-major over a valid/ready port.
module conv_seq_engine #(
  parameter int DW   = 8,
  parameter int IN_H = 4,
  parameter int IN_W = 4,
  parameter int K    = 3,
  parameter int OUTW = 8,
  parameter bit SAT  = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  conv_seq_if.slave bus
);
  localparam int OH   = IN_H - K + 1;
  localparam int OWD  = IN_W - K + 1;
  localparam int RW   = (OH  > 1) ? $clog2(OH)  : 1;
  localparam int CW   = (OWD > 1) ? $clog2(OWD) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int NPIX = IN_H * IN_W;
  localparam int NTAP = K * K;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int PRW  = 2 * DW;
  localparam int ACCW = PRW + ((NTAP > 1) ? $clog2(NTAP) : 0);

  localparam logic [OUTW-1:0] OUT_ONES = '1;
  localparam logic [ACCW-1:0] OUT_MAX  = {{(ACCW-OUTW){1'b0}}, OUT_ONES};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [KW-1:0]   i_q, i_d, j_q, j_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic            load;

  logic [DW-1:0]   img_q [NPIX];
  logic [DW-1:0]   ker_q [NTAP];
  logic            flip_q;

  logic [PW-1:0]   pix_idx;
  logic [TW-1:0]   tap_idx;
  logic [PRW-1:0]  prod;
  int              tap_lin;

  // Flipping a K x K kernel by 180 degrees maps linear tap t onto K*K-1-t.
  always_comb begin
    tap_lin = int'(i_q) * K + int'(j_q);
    pix_idx = PW'((int'(r_q) + int'(i_q)) * IN_W + int'(c_q) + int'(j_q));
    tap_idx = flip_q ? TW'(NTAP - 1 - tap_lin) : TW'(tap_lin);
    prod    = PRW'(img_q[pix_idx]) * PRW'(ker_q[tap_idx]);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    r_d     = r_q;
    c_d     = c_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (j_q == KW'(K - 1)) begin
          j_d = '0;
          if (i_q == KW'(K - 1)) begin
            i_d     = '0;
            state_d = S_EMIT;
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          state_d = S_MAC;
          if (c_q == CW'(OWD - 1)) begin
            c_d = '0;
            if (r_q == RW'(OH - 1)) begin
              r_d     = '0;
              state_d = S_DONE;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // NOTE: operand storage is deliberately unreset; it is always reloaded before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      flip_q <= bus.flip;
      for (int p = 0; p < NPIX; p++) img_q[p] <= bus.img_flat[p*DW +: DW];
      for (int t = 0; t < NTAP; t++) ker_q[t] <= bus.ker_flat[t*DW +: DW];
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (state_q == S_EMIT) begin
      if (SAT) bus.out_data = (acc_q > OUT_MAX) ? OUT_ONES : acc_q[OUTW-1:0];
      else     bus.out_data = acc_q[OUTW-1:0];
    end
  end

  assign bus.busy      = (state_q == S_MAC) || (state_q == S_EMIT);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_row   = r_q;
  assign bus.out_col   = c_q;
endmodule

// File: tb/tb_conv_seq_engine.sv
// Self-checking bench: a saturating and a truncating engine run side by side on shared
// stimulus; expected results come from a vector table and are scored through a queue.
module tb_conv_seq_engine;
  logic clk = 1'b0;
  logic rst;
  logic start, flip, ready;
  logic [127:0] img;
  logic [71:0]  ker;

  always #5 clk = ~clk;

  conv_seq_if if_a ();
  conv_seq_if if_b ();

  assign if_a.start = start;   assign if_b.start = start;
  assign if_a.flip  = flip;    assign if_b.flip  = flip;
  assign if_a.img_flat = img;  assign if_b.img_flat = img;
  assign if_a.ker_flat = ker;  assign if_b.ker_flat = ker;
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  conv_seq_engine #(.SAT(1'b1)) u_sat (.clk(clk), .rst(rst), .bus(if_a));
  conv_seq_engine #(.SAT(1'b0)) u_trn (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct packed {
    logic [1:0]      img_mode;
    logic [2:0]      ker_mode;
    logic            flip;
    logic [3:0][7:0] exp_a;
    logic [3:0][7:0] exp_b;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       row;
    logic       col;
  } exp_t;

  vec_t vecs [8];
  exp_t sbq [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int im, input int km, input bit f,
                              input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    vec_t v;
    v.img_mode = 2'(im);
    v.ker_mode = 3'(km);
    v.flip     = f;
    v.exp_a    = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.exp_b    = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return v;
  endfunction

  // Image modes: 0 all ones, 1 ramp 1..16, 2 all 255.
  function automatic logic [127:0] fill_img(input int mode);
    logic [127:0] v = '0;
    for (int p = 0; p < 16; p++)
      v[p*8 +: 8] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'(p + 1) : 8'd255;
    return v;
  endfunction

  // Kernel modes: 0 all ones, 1 centre only, 2 tap (0,0) only, 3 tap (0,1) only, 4 all 255.
  function automatic logic [71:0] fill_ker(input int mode);
    logic [71:0] v = '0;
    for (int t = 0; t < 9; t++) begin
      case (mode)
        0: v[t*8 +: 8] = 8'd1;
        1: v[t*8 +: 8] = (t == 4) ? 8'd1 : 8'd0;
        2: v[t*8 +: 8] = (t == 0) ? 8'd1 : 8'd0;
        3: v[t*8 +: 8] = (t == 1) ? 8'd1 : 8'd0;
        default: v[t*8 +: 8] = 8'd255;
      endcase
    end
    return v;
  endfunction

  task automatic run(input int v, input int stall, input bit poke);
    int   cyc, n, exp_done;
    bit   done_seen, stalled;
    exp_t e;
    img  = fill_img(int'(vecs[v].img_mode));
    ker  = fill_ker(int'(vecs[v].ker_mode));
    flip = vecs[v].flip;
    for (int k = 0; k < 4; k++)
      sbq.push_back('{a: vecs[v].exp_a[k], b: vecs[v].exp_b[k], row: 1'(k / 2), col: 1'(k % 2)});
    exp_done  = 41 + stall;
    n         = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    cyc   = 0;
    while (!done_seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 5 || cyc == exp_done);
      if (cyc == 1) begin
        img  = {4{$urandom()}};
        ker  = 72'({3{$urandom()}});
        flip = ~flip;
        check("busy_after_start", int'(if_a.busy), 1);
      end
      stalled = (stall > 0) && (cyc >= 10) && (cyc < 10 + stall);
      ready   = !stalled;
      if (stalled) begin
        check("stall_valid_held", int'(if_a.out_valid), 1);
        if (sbq.size() > 0) check("stall_data_held", int'(if_a.out_data), int'(sbq[0].a));
      end
      if (if_a.out_valid && ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("v%0d_r%0d_sat", v, n), int'(if_a.out_data), int'(e.a));
          check($sformatf("v%0d_r%0d_trunc", v, n), int'(if_b.out_data), int'(e.b));
          check($sformatf("v%0d_r%0d_row", v, n), int'(if_a.out_row), int'(e.row));
          check($sformatf("v%0d_r%0d_col", v, n), int'(if_a.out_col), int'(e.col));
          check($sformatf("v%0d_r%0d_cycle", v, n), cyc, (n + 1) * 10 + stall);
          n++;
        end
      end
      if (if_a.done) begin
        done_seen = 1'b1;
        check("done_cycle", cyc, exp_done);
        check("busy_in_done", int'(if_a.busy), 0);
        check("result_count", n, 4);
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    sbq.delete();
  endtask

  initial begin
    int done_cnt;
    vecs[0] = mk(0, 0, 0,   9,   9,   9,   9,  9,  9,  9,  9);
    vecs[1] = mk(1, 1, 0,   6,   7,  10,  11,  6,  7, 10, 11);
    vecs[2] = mk(1, 1, 1,   6,   7,  10,  11,  6,  7, 10, 11);
    vecs[3] = mk(1, 2, 0,   1,   2,   5,   6,  1,  2,  5,  6);
    vecs[4] = mk(1, 2, 1,  11,  12,  15,  16, 11, 12, 15, 16);
    vecs[5] = mk(2, 4, 0, 255, 255, 255, 255,  9,  9,  9,  9);
    vecs[6] = mk(1, 3, 0,   2,   3,   6,   7,  2,  3,  6,  7);
    vecs[7] = mk(1, 3, 1,  10,  11,  14,  15, 10, 11, 14, 15);

    rst = 1'b1; start = 1'b0; ready = 1'b1; flip = 1'b0; img = '0; ker = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  int'(if_a.busy), 0);
    check("rst_valid", int'(if_a.out_valid), 0);
    check("rst_done",  int'(if_a.done), 0);
    check("rst_data",  int'(if_a.out_data), 0);
    check("rst_row",   int'(if_a.out_row), 0);
    check("rst_col",   int'(if_a.out_col), 0);
    rst = 1'b0;

    // start coinciding with rst must not launch a run
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("start_with_rst_ignored", int'(if_a.busy), 0);
    @(posedge clk); #1;
    check("start_with_rst_still_idle", int'(if_a.busy), 0);

    for (int v = 0; v < 8; v++) run(v, 0, 1'b0);
    run(0, 5, 1'b0);

    // abort during the MAC phase of the second result
    img = fill_img(0); ker = fill_ker(0); flip = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",  int'(if_a.busy), 0);
    check("abort_valid", int'(if_a.out_valid), 0);
    check("abort_done",  int'(if_a.done), 0);
    check("abort_data",  int'(if_a.out_data), 0);
    check("abort_row",   int'(if_a.out_row), 0);
    check("abort_col",   int'(if_a.out_col), 0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (if_a.done || if_a.out_valid) done_cnt++;
    end
    check("no_activity_after_abort", done_cnt, 0);

    // fresh run with start poked while busy and in DONE
    run(0, 0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", int'(if_a.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
